// File: rtl/fdc_pkg.sv
// Shared definitions for the frequency-to-digital converter:
//   - counter width and synchronizer depth defaults
//   - FSM state encoding
//   - bit positions within ui_in / uio_out
//   - gate-length decode helper
package fdc_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PER_W       = 4;  // holds gate lengths up to 8

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_t;

  // ui_in bit map
  localparam int unsigned UI_EN   = 0;
  localparam int unsigned UI_REF  = 1;
  localparam int unsigned UI_MEAS = 2;
  localparam int unsigned UI_BSEL = 3;
  localparam int unsigned UI_GATE = 4;  // two bits, [5:4]

  // uio_out bit map
  localparam int unsigned UIO_VALID = 0;
  localparam int unsigned UIO_OVF   = 1;
  localparam int unsigned UIO_WIN   = 2;
  localparam int unsigned UIO_TOG   = 3;

  // Number of reference periods in one gate window: 1, 2, 4 or 8.
  function automatic logic [PER_W-1:0] gate_periods(input logic [1:0] sel);
    return PER_W'(1) << sel;
  endfunction

endpackage

// File: rtl/fdc_sync_edge.sv
// Synchronizer chain followed by a rising-edge detector.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous reset, active-high
//   i_async asynchronous input level
//   o_rise  one-cycle pulse, STAGES+1 clocks after the input rises
module fdc_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/fdc_chip.sv
// Frequency-to-digital converter on the Tiny Tapeout pin interface.
// Counts measured-signal rising edges over a gate window of 1/2/4/8
// reference periods and latches the count into a result register.
// Ports:
//   clk      system clock
//   rst_n    asynchronous reset, ACTIVE-HIGH despite the name (pin compat)
//   ena      ignored
//   ui_in    [0] enable, [1] reference, [2] measured, [3] byte select,
//            [5:4] gate length select, [7:6] unused
//   uo_out   selected result byte (combinational on ui_in[3])
//   uio_in   unused
//   uio_out  [0] valid, [1] overflow, [2] window open, [3] result toggle
//   uio_oe   constant 8'hFF
module fdc_chip
  import fdc_pkg::*;
#(
  parameter int unsigned CNT_W       = fdc_pkg::CNT_W,
  parameter int unsigned SYNC_STAGES = fdc_pkg::SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic w_rst;
  logic w_en;
  logic w_ref_rise;
  logic w_meas_rise;
  logic w_unused;

  assign w_rst    = rst_n;
  assign w_en     = ui_in[UI_EN];
  assign w_unused = ^{1'b0, ena, uio_in, ui_in[7:6]};

  fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_ref_edge (
    .i_clk   (clk),
    .i_rst   (w_rst),
    .i_async (ui_in[UI_REF]),
    .o_rise  (w_ref_rise)
  );

  fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_meas_edge (
    .i_clk   (clk),
    .i_rst   (w_rst),
    .i_async (ui_in[UI_MEAS]),
    .o_rise  (w_meas_rise)
  );

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_int;
  logic [PER_W-1:0]   r_per;
  logic [PER_W-1:0]   r_gate;
  logic [CNT_W-1:0]   r_result;
  logic               r_ovf;
  logic               r_valid;
  logic               r_toggle;

  logic               w_open;
  logic               w_close;
  logic               w_cnt_sat;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_ovf_inc;

  // Next-state decode; w_open/w_close mark the window boundaries.
  always_comb begin
    w_state_nxt = r_state;
    w_open      = 1'b0;
    w_close     = 1'b0;
    if (!w_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = ARMED;
        ARMED: begin
          if (w_ref_rise) begin
            w_state_nxt = COUNT;
            w_open      = 1'b1;
          end
        end
        COUNT: begin
          if (w_ref_rise && ((r_per + PER_W'(1)) == r_gate)) begin
            w_close = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saturating count including any meas_rise in the current cycle; the
  // closing window latches this value so a coincident edge lands in it.
  always_comb begin
    w_cnt_sat = &r_cnt;
    w_cnt_inc = r_cnt;
    w_ovf_inc = r_ovf_int;
    if (w_meas_rise) begin
      if (w_cnt_sat) begin
        w_ovf_inc = 1'b1;
      end else begin
        w_cnt_inc = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_per     <= '0;
      r_gate    <= PER_W'(1);
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_toggle  <= 1'b0;
    end else if (!w_en) begin
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_per     <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        ARMED: begin
          r_cnt     <= '0;
          r_ovf_int <= 1'b0;
          r_per     <= '0;
          if (w_open) begin
            r_gate <= gate_periods(ui_in[UI_GATE +: 2]);
          end
        end
        COUNT: begin
          if (w_close) begin
            // Back-to-back windows: the closing edge also opens the next.
            r_result  <= w_cnt_inc;
            r_ovf     <= w_ovf_inc;
            r_valid   <= 1'b1;
            r_toggle  <= ~r_toggle;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_per     <= '0;
            r_gate    <= gate_periods(ui_in[UI_GATE +: 2]);
          end else begin
            r_cnt     <= w_cnt_inc;
            r_ovf_int <= w_ovf_inc;
            if (w_ref_rise) begin
              r_per <= r_per + PER_W'(1);
            end
          end
        end
        default: begin
          r_cnt     <= '0;
          r_ovf_int <= 1'b0;
          r_per     <= '0;
        end
      endcase
    end
  end

  logic [15:0] w_res16;
  logic [7:0]  w_uio;

  assign w_res16 = 16'(r_result);
  assign uo_out  = ui_in[UI_BSEL] ? w_res16[15:8] : w_res16[7:0];

  always_comb begin
    w_uio            = '0;
    w_uio[UIO_VALID] = r_valid;
    w_uio[UIO_OVF]   = r_ovf;
    w_uio[UIO_WIN]   = (r_state == COUNT);
    w_uio[UIO_TOG]   = r_toggle;
  end

  assign uio_out = w_uio;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_fdc_chip.sv
module tb_fdc_chip;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       bsel;
  logic [1:0] gsel;
  logic       ref_s;
  logic       meas_s;
  logic [7:0] ui_in;
  logic [7:0] uo0, uio0, oe0;
  logic [7:0] uo1, uio1, oe1;

  assign ui_in = {2'b00, gsel, bsel, meas_s, ref_s, en};

  // Full-width device under test.
  fdc_chip u_dut (
    .clk     (clk),
    .rst_n   (rst),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo0),
    .uio_in  (8'h00),
    .uio_out (uio0),
    .uio_oe  (oe0)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  fdc_chip #(.CNT_W(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo1),
    .uio_in  (8'h00),
    .uio_out (uio1),
    .uio_oe  (oe1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ref_half  = 500;
  int meas_half = 50;
  bit ref_run   = 1'b0;
  bit meas_run  = 1'b0;

  initial begin
    ref_s = 1'b0;
    forever begin
      if (ref_run) begin
        ref_s = 1'b1; #(ref_half);
        ref_s = 1'b0; #(ref_half);
      end else begin
        @(ref_run);
      end
    end
  end

  initial begin
    meas_s = 1'b0;
    forever begin
      if (meas_run) begin
        meas_s = 1'b1; #(meas_half);
        meas_s = 1'b0; #(meas_half);
      end else begin
        @(meas_run);
      end
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic        last_tog = 1'b0;
  logic [15:0] r0, r1;

  function automatic exp_t model(input int n, input int refp, input int measp, input int w);
    exp_t e;
    int raw;
    int mx;
    raw = n * refp / measp;
    mx  = (1 << w) - 1;
    e.res = (raw > mx) ? 16'(mx) : 16'(raw);
    e.ovf = (raw > mx);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; both selects are read combinationally.
  task automatic read_bytes();
    bsel = 1'b0; #1;
    r0[7:0] = uo0; r1[7:0] = uo1;
    bsel = 1'b1; #1;
    r0[15:8] = uo0; r1[15:8] = uo1;
    bsel = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int budget);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uio0[3] !== last_tog) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (got) else begin
      n_bad++;
      $error("FAIL %s_timeout observed=no_toggle expected=toggle_within_%0d_cycles", tag, budget);
    end
    if (got) begin
      last_tog = uio0[3];
      e = sb.pop_front();
      read_bytes();
      chk({tag, "_lo"},    {8'h00, r0[7:0]},  {8'h00, e.res[7:0]});
      chk({tag, "_hi"},    {8'h00, r0[15:8]}, {8'h00, e.res[15:8]});
      chk({tag, "_valid"}, {15'd0, uio0[0]},  16'd1);
      chk({tag, "_ovf"},   {15'd0, uio0[1]},  {15'd0, e.ovf});
    end
  endtask

  exp_t es;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    bsel = 1'b0;
    gsel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_uo",  {8'h00, uo0},  16'h0000);
    chk("rst_uio", {8'h00, uio0}, 16'h0000);
    chk("rst_oe",  {8'h00, oe0},  16'h00FF);
    rst = 1'b0;

    // Basic count; ref and meas edges coincide at every ref edge.
    @(negedge clk);
    ref_half = 500; meas_half = 50; gsel = 2'd0;
    ref_run = 1'b1; meas_run = 1'b1; en = 1'b1;
    sb.push_back(model(1, 1000, 100, 16));
    sb.push_back(model(1, 1000, 100, 16));
    repeat (50) @(negedge clk);
    chk("win_open",  {15'd0, uio0[2]}, 16'd1);
    chk("valid_pre", {15'd0, uio0[0]}, 16'd0);
    wait_result("basic1", 150);
    wait_result("basic2", 150);

    // Gate select is picked up by the next window to open, not the current one.
    gsel = 2'd3;
    sb.push_back(model(1, 1000, 100, 16));
    sb.push_back(model(8, 1000, 100, 16));
    wait_result("gate_n1", 150);
    wait_result("gate_n8", 900);

    // Asynchronous reset in the middle of a window.
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_uo",  {8'h00, uo0},  16'h0000);
    chk("arst_uio", {8'h00, uio0}, 16'h0000);
    chk("arst_oe",  {8'h00, oe0},  16'h00FF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    last_tog = 1'b0;
    sb.push_back(model(8, 1000, 100, 16));
    repeat (300) @(negedge clk);
    chk("rst_valid_hold", {15'd0, uio0[0]}, 16'd0);
    wait_result("rst_recover", 1000);

    // Disable mid-window, then re-enable: first ref edge only arms.
    repeat (300) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_valid", {15'd0, uio0[0]}, 16'd0);
    chk("dis_win",   {15'd0, uio0[2]}, 16'd0);
    chk("dis_hold",  {8'h00, uo0},     16'h0050);
    gsel = 2'd0;
    repeat (37) @(negedge clk);
    en = 1'b1;
    sb.push_back(model(1, 1000, 100, 16));
    wait_result("reenable", 250);

    // Overflow on the narrow copy, followed by an in-range window.
    en = 1'b0; ref_run = 1'b0; meas_run = 1'b0;
    repeat (200) @(negedge clk);
    ref_half = 2000; meas_half = 20; gsel = 2'd2;
    ref_run = 1'b1; meas_run = 1'b1; en = 1'b1;
    sb.push_back(model(4, 4000, 40, 16));
    sb.push_back(model(1, 4000, 40, 16));
    repeat (800) @(negedge clk);
    gsel = 2'd0;
    wait_result("ovf_full", 1000);
    es = model(4, 4000, 40, 8);
    chk("ovf8_lo",    {8'h00, r1[7:0]},  {8'h00, es.res[7:0]});
    chk("ovf8_hi",    {8'h00, r1[15:8]}, {8'h00, es.res[15:8]});
    chk("ovf8_flag",  {15'd0, uio1[1]},  {15'd0, es.ovf});
    chk("ovf8_valid", {15'd0, uio1[0]},  16'd1);
    wait_result("inrange_full", 500);
    es = model(1, 4000, 40, 8);
    chk("inr8_lo",   {8'h00, r1[7:0]},  {8'h00, es.res[7:0]});
    chk("inr8_hi",   {8'h00, r1[15:8]}, {8'h00, es.res[15:8]});
    chk("inr8_flag", {15'd0, uio1[1]},  {15'd0, es.ovf});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fdc_chip.md
Name: fdc_chip

Overview:
- Frequency-to-digital converter (FDC) behind the Tiny Tapeout user-project pin interface.
- Counts rising edges of a measured signal inside a gate window made of 1, 2, 4 or 8 periods of a reference pulse train.
- Latches the count as a 16-bit result and presents either byte on the dedicated outputs, with status on the bidirectional pins.
- All logic runs in the clk domain; both external signals are asynchronous and are synchronized internally.

Parameters:
- CNT_W, 16, width of the edge counter and result register (must be 16 for the byte mux below).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high: 1 = reset, 0 = run. The name is kept for pin compatibility only.
- ena  in  1  design-selected flag; ignored.
- ui_in  in  8  [0] measure enable; [1] reference pulse; [2] measured signal; [3] byte select (0 = low, 1 = high); [5:4] gate length select; [7:6] unused.
- uo_out  out  8  selected result byte.
- uio_in  in  8  unused.
- uio_out  out  8  [0] valid; [1] overflow; [2] window open; [3] result toggle; [7:4] = 0.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Reset (asynchronous, rst_n=1): clears synchronizers, edge-detect registers, counter, period counter, result, and all status bits.
  - While reset is held: uo_out=0, uio_out=0, uio_oe=8'hFF.
  - Reset mid-window discards the partial count.
- Input conditioning:
  - ui_in[1] and ui_in[2] each pass through a SYNC_STAGES flop chain, then a rising-edge detector (sync & ~prev).
  - The detector yields one-cycle pulses ref_rise and meas_rise.
  - Latency from pin edge to pulse is SYNC_STAGES+1 clk cycles.
  - Each level must be held for at least 2 clk periods to be counted; shorter pulses may be lost.
- Gate length: N = 1 << ui_in[5:4], giving 1, 2, 4 or 8 reference periods. ui_in[5:4] is sampled when a window opens and is held for that window.
- State machine: IDLE, ARMED, COUNT.
  - IDLE: entered on reset or whenever enable (ui_in[0], sampled directly each cycle) is 0. Counter and period counter are cleared; result, valid and overflow are held, except that enable=0 clears valid.
  - IDLE to ARMED: when enable=1.
  - ARMED to COUNT: on the first ref_rise. Counter is cleared, period counter is set to 0, and window-open goes to 1.
  - In COUNT, each meas_rise increments the counter. The counter saturates at 2^CNT_W-1 and sets an internal overflow flag.
  - In COUNT, each ref_rise increments the period counter.
  - When the period counter reaches N:
    - result <= count, including a meas_rise in the same cycle.
    - overflow <= internal flag.
    - valid <= 1; toggle inverts.
    - Counter and flag are cleared, excluding that same-cycle meas_rise. The next window starts immediately with no gap, so FSM stays in COUNT.
  - Result registers update on the clk edge that samples the closing ref_rise pulse.
- Output:
  - uo_out = ui_in[3] ? result[15:8] : result[7:0]. This is combinational from ui_in[3], so a byte switch takes effect with no clk delay.
  - uio_out[2] = 1 in COUNT state only.

Decomposition:
- Package fdc_pkg: CNT_W, SYNC_STAGES, the state enum (IDLE/ARMED/COUNT), and the ui_in/uio_out bit-index constants.
- One sub-module is natural: fdc_sync_edge (parameterized synchronizer plus rising-edge detector). Instantiate it twice.
- Counter, FSM and output mux stay in the top level.

Test Plan:
- Reset: assert rst_n=1 mid-operation. Outputs go to 0 asynchronously, uio_oe=8'hFF. Deassert, then wait: valid stays 0 until a full window completes.
- Basic count: clk 10 ns, enable=1, gate select=0, ref rising every 1000 ns, meas rising every 100 ns (50% duty). After the 2nd ref edge: result=10, valid=1, overflow=0, uo_out=8'h0A with select=0 and 8'h00 with select=1.
- Gate length: same stimulus, ui_in[5:4]=2'b11. Result=80 after 8 ref periods. The toggle bit flips once per window.
- Overflow: meas period 40 ns, ref period 3 ms (75000 edges). Result=16'hFFFF, overflow=1, uo_out=8'hFF for both selects. The next in-range window clears overflow.
- Disable: drop ui_in[0] mid-window. Valid goes to 0, window-open goes to 0, result is held. Re-enable: the first ref edge only arms, the next produces a fresh result.
- Boundary: meas_rise and ref_rise in the same cycle. That edge is included in the latched result and not in the next window's count.
